// File: rtl/prefetch_buffer_if.sv
// Instruction memory port between the prefetcher (master) and memory (slave):
// request/grant for addresses, then an in-order response strobe with the word.
interface prefetch_buffer_if #(
   parameter int unsigned WORD_WIDTH = 32
);
   logic                  instr_req_o;
   logic [WORD_WIDTH-1:0] instr_addr_o;
   logic                  instr_gnt_i;
   logic                  instr_rvalid_i;
   logic [WORD_WIDTH-1:0] instr_rdata_i;

   modport master (
      output instr_req_o,
      output instr_addr_o,
      input  instr_gnt_i,
      input  instr_rvalid_i,
      input  instr_rdata_i
   );

   modport slave (
      input  instr_req_o,
      input  instr_addr_o,
      output instr_gnt_i,
      output instr_rvalid_i,
      output instr_rdata_i
   );
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetcher: keeps several fetches in flight, queues returned words
// in a small FIFO for decode, and squashes stale responses on a branch redirect.
module prefetch_buffer #(
   parameter int unsigned WORD_WIDTH      = 32,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en_i,
   input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
   input  logic                  branch_i,
   input  logic [WORD_WIDTH-1:0] branch_addr_i,
   prefetch_buffer_if.master     imem,
   output logic                  valid_o,
   output logic [WORD_WIDTH-1:0] instr_o,
   output logic [WORD_WIDTH-1:0] addr_o,
   input  logic                  ready_i,
   output logic                  busy_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SUM_W = CNT_W + OUT_W;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                state_q;
   logic                  started_q;
   logic [WORD_WIDTH-1:0] fetch_addr_q;
   logic [WORD_WIDTH-1:0] rsp_addr_q;
   logic [OUT_W-1:0]      outstanding_q;
   logic [OUT_W-1:0]      discard_q;
   logic                  held_q;
   logic                  pend_q;
   logic [WORD_WIDTH-1:0] pend_addr_q;

   logic [WORD_WIDTH-1:0] instr_mem [DEPTH];
   logic [WORD_WIDTH-1:0] addr_mem  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [WORD_WIDTH-1:0] target_c;
   logic                  credit_ok_c;
   logic                  issue_c;
   logic                  req_c;
   logic                  fire_c;
   logic                  stall_c;
   logic                  push_c;
   logic                  pop_c;
   logic [OUT_W-1:0]      out_next_c;
   logic                  unused_addr_lsbs;

   assign target_c         = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
   assign unused_addr_lsbs = &{1'b0, branch_addr_i[1:0]};

   // Credit counts words already queued plus live (non-discarded) fetches
   assign credit_ok_c = (SUM_W'(cnt_q) + SUM_W'(outstanding_q) - SUM_W'(discard_q))
                        < SUM_W'(DEPTH);
   assign issue_c     = (state_q == RUN) && fetch_en_i
                        && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && credit_ok_c;
   // A request once raised is held until granted, regardless of enable or branch
   assign req_c       = held_q || issue_c;
   assign fire_c      = req_c && imem.instr_gnt_i;
   assign stall_c     = req_c && !imem.instr_gnt_i;
   assign out_next_c  = outstanding_q + OUT_W'(fire_c) - OUT_W'(imem.instr_rvalid_i);
   assign push_c      = imem.instr_rvalid_i && !branch_i && (discard_q == '0);
   assign pop_c       = (cnt_q != '0) && ready_i;

   assign imem.instr_req_o  = req_c;
   assign imem.instr_addr_o = fetch_addr_q;

   assign valid_o = (cnt_q != '0);
   assign instr_o = instr_mem[rd_ptr_q];
   assign addr_o  = addr_mem[rd_ptr_q];
   assign busy_o  = (outstanding_q != '0) || req_c;

   // Fetch control: state, addresses, in-flight and discard accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         started_q     <= 1'b0;
         fetch_addr_q  <= '0;
         rsp_addr_q    <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         held_q        <= 1'b0;
         pend_q        <= 1'b0;
         pend_addr_q   <= '0;
      end else begin
         held_q        <= stall_c;
         outstanding_q <= out_next_c;

         case (state_q)
            IDLE: begin
               if (fetch_en_i) begin
                  state_q <= RUN;
                  if (!started_q) begin
                     started_q    <= 1'b1;
                     fetch_addr_q <= pc_start_addr_i;
                     rsp_addr_q   <= pc_start_addr_i;
                  end
               end
            end
            RUN: begin
               if (!fetch_en_i && !req_c && (outstanding_q == '0)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (push_c) begin
            rsp_addr_q <= rsp_addr_q + WORD_WIDTH'(4);
         end

         // A request granted after a redirect jumps to the saved target
         if (fire_c) begin
            fetch_addr_q <= pend_q ? pend_addr_q : fetch_addr_q + WORD_WIDTH'(4);
            pend_q       <= 1'b0;
         end

         if (branch_i) begin
            discard_q  <= out_next_c;
            rsp_addr_q <= target_c;
            if (stall_c) begin
               pend_q      <= 1'b1;
               pend_addr_q <= target_c;
            end else begin
               pend_q       <= 1'b0;
               fetch_addr_q <= target_c;
            end
         end else begin
            discard_q <= discard_q
                         - OUT_W'(imem.instr_rvalid_i && (discard_q != '0))
                         + OUT_W'(fire_c && pend_q);
         end
      end
   end

   // Word FIFO; a redirect empties it in one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            addr_mem[i]  <= '0;
         end
      end else if (branch_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_c) begin
            instr_mem[wr_ptr_q] <= imem.instr_rdata_i;
            addr_mem[wr_ptr_q]  <= rsp_addr_q;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   overflow_chk : assert property (@(posedge clk) disable iff (rst)
      !(push_c && !pop_c && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomized bench for prefetch_buffer: the bench is the memory, and a program-order
// model checks the request addresses, the decode stream, occupancy and busy.
module tb_prefetch_buffer;

   localparam int unsigned WW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_en;
   logic [WW-1:0] pc_start;
   logic          branch;
   logic [WW-1:0] branch_addr;
   logic          valid;
   logic [WW-1:0] instr;
   logic [WW-1:0] addr;
   logic          ready;
   logic          busy;

   prefetch_buffer_if #(.WORD_WIDTH(WW)) bus ();

   prefetch_buffer #(
      .WORD_WIDTH      (WW),
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_en_i      (fetch_en),
      .pc_start_addr_i (pc_start),
      .branch_i        (branch),
      .branch_addr_i   (branch_addr),
      .imem            (bus),
      .valid_o         (valid),
      .instr_o         (instr),
      .addr_o          (addr),
      .ready_i         (ready),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] a;
      int            due;
      bit            stale;
   } rsp_t;

   rsp_t          mem_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            last_due = 0;
   int            occ = 0;
   int            pops = 0;
   int            grants = 0;
   logic [WW-1:0] exp_pc, exp_req, pend_tgt, prev_addr;
   bit            pend, prev_held, seen_req, last_req;
   int            p_fen = 100, p_gnt = 100, p_rdy = 100, p_br = 0;
   int            lat_lo = 1, lat_hi = 1;
   bit            force_br = 0;
   logic [WW-1:0] force_tgt = '0;

   task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [WW-1:0] word_of(input logic [WW-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
   endfunction

   // One clock cycle: drive inputs, sample outputs, check, advance the model
   task automatic step();
      logic          req, gnt, rv;
      logic [WW-1:0] ra, tgt;
      rsp_t          h;
      int            lat, due;
      @(posedge clk);
      #1;
      cyc++;
      fetch_en = ($urandom_range(99) < p_fen);
      gnt      = ($urandom_range(99) < p_gnt);
      ready    = ($urandom_range(99) < p_rdy);
      branch   = force_br || (seen_req && ($urandom_range(99) < p_br));
      branch_addr = force_br ? force_tgt : ($urandom & 32'h0000_3FFF);
      force_br = 1'b0;
      rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      bus.instr_gnt_i    = gnt;
      bus.instr_rvalid_i = rv;
      bus.instr_rdata_i  = rv ? word_of(mem_q[0].a) : $urandom;
      #1;
      req = bus.instr_req_o;
      ra  = bus.instr_addr_o;
      tgt = {branch_addr[WW-1:2], 2'b00};

      check_eq("valid", valid, occ != 0);
      check_eq("busy", busy, (mem_q.size() != 0) || req);
      check_eq("max_outstanding", mem_q.size() <= MAXO, 1);
      if (prev_held) begin
         check_eq("req_hold", req, 1);
         check_eq("addr_hold", ra, prev_addr);
      end
      if (valid && ready) begin
         check_eq("addr_o", addr, exp_pc);
         check_eq("instr_o", instr, word_of(exp_pc));
         exp_pc += 4;
         occ--;
         pops++;
      end
      if (rv) begin
         h = mem_q.pop_front();
         if (!h.stale && !branch) occ++;
      end
      if (branch) begin
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         occ    = 0;
         exp_pc = tgt;
      end
      if (req && gnt) begin
         check_eq("req_addr", ra, exp_req);
         lat = $urandom_range(lat_hi, lat_lo);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{a: ra, due: due, stale: branch || pend});
         grants++;
         seen_req = 1'b1;
         if (branch) begin
            exp_req = tgt;
            pend    = 1'b0;
         end else if (pend) begin
            exp_req = pend_tgt;
            pend    = 1'b0;
         end else begin
            exp_req += 4;
         end
      end else if (branch) begin
         if (req) begin
            pend     = 1'b1;
            pend_tgt = tgt;
         end else begin
            exp_req = tgt;
         end
      end
      check_eq("occupancy", occ <= DEPTH, 1);
      prev_held = req && !gnt;
      prev_addr = ra;
      last_req  = req;
   endtask

   task automatic do_reset(input logic [WW-1:0] pc);
      rst                = 1'b1;
      fetch_en           = 1'b0;
      branch             = 1'b0;
      branch_addr        = '0;
      ready              = 1'b0;
      pc_start           = pc;
      bus.instr_gnt_i    = 1'b0;
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
      repeat (2) @(posedge clk);
      #2;
      check_eq("rst_req", bus.instr_req_o, 0);
      check_eq("rst_addr", bus.instr_addr_o, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_addr_o", addr, 0);
      check_eq("rst_busy", busy, 0);
      mem_q.delete();
      occ       = 0;
      last_due  = 0;
      exp_pc    = pc;
      exp_req   = pc;
      pend      = 1'b0;
      prev_held = 1'b0;
      seen_req  = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      int g0;
      int k;

      // Streaming from pc_start with an always-granting, 1-cycle memory
      do_reset(32'h0000_0080);
      repeat (20) step();

      // Decode stalls: FIFO fills to DEPTH and requests stop
      p_rdy = 0;
      repeat (12) step();
      check_eq("t2_fifo_full", occ, DEPTH);
      check_eq("t2_req_off", last_req, 0);
      check_eq("t2_valid", valid, 1);
      g0 = grants;
      p_rdy = 100;
      step();
      p_rdy = 0;
      repeat (10) step();
      check_eq("t2_one_refill", grants - g0, 1);
      p_rdy = 100;
      repeat (12) step();

      // Held request with a redirect to 0x200 during the grant stall
      p_gnt = 0;
      k = 0;
      while (k < 10 && !last_req) begin
         step();
         k++;
      end
      check_eq("t3_req_held", last_req, 1);
      force_br  = 1'b1;
      force_tgt = 32'h0000_0200;
      step();
      step();
      p_gnt = 100;
      repeat (20) step();

      // Two in flight, then a redirect to 0x1000
      lat_lo = 3;
      lat_hi = 3;
      k = 0;
      while (k < 20 && mem_q.size() != 2) begin
         step();
         k++;
      end
      check_eq("t4_two_out", mem_q.size(), 2);
      force_br  = 1'b1;
      force_tgt = 32'h0000_1000;
      step();
      repeat (20) step();
      lat_lo = 1;
      lat_hi = 1;

      // Fetch enable pause and resume, then a reset mid-stream
      p_fen = 0;
      repeat (10) step();
      check_eq("t6_idle_busy", busy, 0);
      p_fen = 100;
      repeat (20) step();
      do_reset(32'h0000_0400);
      repeat (20) step();

      // Randomized traffic across several mixes
      for (int ph = 0; ph < 4; ph++) begin
         p_fen  = 70 + 10 * ph;
         p_gnt  = 40 + 15 * ph;
         p_rdy  = 90 - 15 * ph;
         p_br   = 2 + 2 * ph;
         lat_lo = 1;
         lat_hi = 1 + ph;
         repeat (1500) step();
      end
      check_eq("progress", pops > 500, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
